// File: rtl/key_expansion.sv
// key_expansion -- sequential AES-128 key schedule, one round key per request.
//
// The cipher key is loaded once as round 0. Each later round key is made by a
// three-cycle step: VALID (request seen) -> LOOKUP (S-box ROMs addressed with
// RotWord(w3)) -> EXPAND (XOR chain, round+1) -> VALID.
//
// Ports:
//   clk          in   1    rising-edge clock
//   reset        in   1    synchronous, active-high
//   key_load     in   1    load key as round 0; aborts any step in flight
//   key          in 128    cipher key, key[127:96] = w0, key[31:0] = w3
//   next         in   1    request the following round key
//   round_key    out 128   current round key, same order as key
//   round        out  4    round index of round_key, 0..10
//   key_valid    out  1    round_key/round are stable and usable
//   busy         out  1    expansion step in progress
//   last         out  1    key_valid & (round == 10)
//   dbg_state_o  out  2    FSM state for observation
//
// Handshake: next is accepted only on an edge where key_valid is 1 and
// round < 10; while busy is 1 next is ignored (never queued). key_valid and
// busy are never both 1. key_load is always accepted and outranks next;
// reset outranks both.
module key_expansion (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] key,
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round,
  output logic         key_valid,
  output logic         busy,
  output logic         last,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VALID  = 2'd1,
    LOOKUP = 2'd2,
    EXPAND = 2'd3
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_e       state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_q, round_d;
  logic [31:0]  sub_q;   // registered SubWord(RotWord(w3)), valid in EXPAND
  logic [7:0]   rcon;
  logic [31:0]  w0, w1, w2, w3, t, w0n, w1n, w2n, w3n;

  // Four synchronous S-box ROMs, no reset so they map onto block RAM.
  // Addressed every cycle from w3; round_key_q is frozen during LOOKUP, so
  // the value captured at the end of LOOKUP is the one EXPAND consumes.
  always_ff @(posedge clk) begin
    sub_q[31:24] <= SBOX[round_key_q[23:16]];
    sub_q[23:16] <= SBOX[round_key_q[15:8]];
    sub_q[15:8]  <= SBOX[round_key_q[7:0]];
    sub_q[7:0]   <= SBOX[round_key_q[31:24]];
  end

  // Round constant for the round being produced (round_q + 1).
  always_comb begin
    rcon = 8'h00;
    case (round_q + 4'd1)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    w0  = round_key_q[127:96];
    w1  = round_key_q[95:64];
    w2  = round_key_q[63:32];
    w3  = round_key_q[31:0];
    t   = sub_q ^ {rcon, 24'h000000};
    w0n = w0 ^ t;
    w1n = w1 ^ w0n;
    w2n = w2 ^ w1n;
    w3n = w3 ^ w2n;
  end

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_d     = round_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      VALID:   if (next && (round_q != 4'd10)) state_d = LOOKUP;
      LOOKUP:  state_d = EXPAND;
      EXPAND: begin
        round_key_d = {w0n, w1n, w2n, w3n};
        round_d     = round_q + 4'd1;
        state_d     = VALID;
      end
      default: state_d = IDLE;
    endcase
    // Load wins over everything in flight, including a pending EXPAND write.
    if (key_load) begin
      round_key_d = key;
      round_d     = 4'd0;
      state_d     = VALID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      round_key_q <= 128'h0;
      round_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_q     <= round_d;
    end
  end

  assign round_key   = round_key_q;
  assign round       = round_q;
  assign key_valid   = (state_q == VALID);
  assign busy        = (state_q == LOOKUP) || (state_q == EXPAND);
  assign last        = key_valid && (round_q == 4'd10);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_expansion.sv
module tb_key_expansion;

  logic         clk = 1'b0;
  logic         reset, key_load, next;
  logic [127:0] key;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic         key_valid, busy, last;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sbox_m [256];

  localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KAT_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KAT_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;

  always #5 clk = ~clk;

  key_expansion dut (
    .clk(clk), .reset(reset), .key_load(key_load), .key(key), .next(next),
    .round_key(round_key), .round(round), .key_valid(key_valid),
    .busy(busy), .last(last), .dbg_state_o(dbg_state)
  );

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  // S-box built from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic logic [127:0] model_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; key_load = 1'b0; next = 1'b0; key = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    key = k; key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if ({round_key, round, key_valid, busy, last} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got key=%h round=%0d v=%b b=%b l=%b want all 0", round_key, round, key_valid, busy, last);
    end
    next = 1'b1; tick(); tick(); next = 1'b0;
    n_cmp++; if ({round_key, round, key_valid, busy} !== '0) begin
      n_err++; $display("FAIL idle_ignores_next: got key=%h round=%0d v=%b b=%b want all 0", round_key, round, key_valid, busy);
    end
  endtask

  task automatic test_load();
    load_key(KAT_KEY);
    n_cmp++; if ({key_valid, busy, last, round, round_key} !== {3'b100, 4'd0, KAT_KEY}) begin
      n_err++; $display("FAIL load_round0: got v=%b b=%b l=%b round=%0d key=%h want v=1 b=0 l=0 round=0 key=%h", key_valid, busy, last, round, round_key, KAT_KEY);
    end
  endtask

  task automatic test_single_next();
    next = 1'b1; tick(); next = 1'b0;
    n_cmp++; if ({key_valid, busy, round_key} !== {2'b01, KAT_KEY}) begin
      n_err++; $display("FAIL next_cycle1: got v=%b b=%b key=%h want v=0 b=1 key held", key_valid, busy, round_key);
    end
    tick();
    n_cmp++; if ({key_valid, busy, round_key} !== {2'b01, KAT_KEY}) begin
      n_err++; $display("FAIL next_cycle2: got v=%b b=%b key=%h want v=0 b=1 key held", key_valid, busy, round_key);
    end
    tick();
    n_cmp++; if ({key_valid, busy, round, round_key} !== {2'b10, 4'd1, KAT_R1}) begin
      n_err++; $display("FAIL next_round1: got v=%b b=%b round=%0d key=%h want v=1 b=0 round=1 key=%h", key_valid, busy, round, round_key, KAT_R1);
    end
  endtask

  task automatic test_held_next();
    int cyc = 0;
    logic [127:0] held;
    key = KAT_KEY; key_load = 1'b1; next = 1'b1;
    tick();
    key_load = 1'b0;
    while (!(key_valid && round == 4'd10) && cyc < 60) begin
      n_cmp++; if (key_valid && busy) begin
        n_err++; $display("FAIL valid_busy_exclusive: got both 1 want not both");
      end
      tick(); cyc++;
    end
    n_cmp++; if (cyc !== 30) begin
      n_err++; $display("FAIL held_next_cycles: got %0d want 30", cyc);
    end
    n_cmp++; if ({round_key, last} !== {KAT_R10, 1'b1}) begin
      n_err++; $display("FAIL round10_key: got key=%h last=%b want key=%h last=1", round_key, last, KAT_R10);
    end
    held = round_key;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({round, busy, key_valid, last, round_key} !== {4'd10, 3'b011, held}) begin
        n_err++; $display("FAIL next_at_round10: got round=%0d b=%b v=%b l=%b key=%h want round=10 b=0 v=1 l=1 key=%h", round, busy, key_valid, last, round_key, held);
      end
    end
    next = 1'b0;
  endtask

  task automatic test_next_during_lookup();
    load_key('0);
    next = 1'b1; tick(); next = 1'b0;
    next = 1'b1; tick(); next = 1'b0;   // in LOOKUP: must be ignored
    tick();
    n_cmp++; if ({key_valid, round, round_key} !== {1'b1, 4'd1, ZERO_R1}) begin
      n_err++; $display("FAIL zero_key_round1: got v=%b round=%0d key=%h want v=1 round=1 key=%h", key_valid, round, round_key, ZERO_R1);
    end
    tick(); tick(); tick();
    n_cmp++; if ({key_valid, busy, round} !== {2'b10, 4'd1}) begin
      n_err++; $display("FAIL lookup_next_not_queued: got v=%b b=%b round=%0d want v=1 b=0 round=1", key_valid, busy, round);
    end
  endtask

  task automatic test_abort_load();
    logic [127:0] k1 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] k2 = {$urandom, $urandom, $urandom, $urandom};
    load_key(k1);
    next = 1'b1; tick(); next = 1'b0;
    tick();                             // now in EXPAND
    load_key(k2);
    n_cmp++; if ({key_valid, busy, round, round_key} !== {2'b10, 4'd0, k2}) begin
      n_err++; $display("FAIL abort_load: got v=%b b=%b round=%0d key=%h want v=1 b=0 round=0 key=%h", key_valid, busy, round, round_key, k2);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({key_valid, round, round_key} !== {1'b1, 4'd0, k2}) begin
        n_err++; $display("FAIL abort_no_leak: got v=%b round=%0d key=%h want v=1 round=0 key=%h", key_valid, round, round_key, k2);
      end
    end
  endtask

  task automatic test_reset_in_lookup();
    load_key(KAT_KEY);
    next = 1'b1; tick(); next = 1'b0;   // now in LOOKUP
    reset = 1'b1; key_load = 1'b1; key = KAT_KEY;
    tick();
    reset = 1'b0; key_load = 1'b0;
    n_cmp++; if ({round_key, round, key_valid, busy, last} !== '0) begin
      n_err++; $display("FAIL reset_mid_step: got key=%h round=%0d v=%b b=%b l=%b want all 0", round_key, round, key_valid, busy, last);
    end
    next = 1'b1; tick(); next = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if ({round_key, round, key_valid, busy, last} !== '0) begin
      n_err++; $display("FAIL next_after_reset: got key=%h round=%0d v=%b b=%b l=%b want all 0", round_key, round, key_valid, busy, last);
    end
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 4; n++) begin
      logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k);
      for (int r = 1; r <= 10; r++) begin
        int cyc = 0;
        repeat ($urandom_range(0, 2)) tick();
        next = 1'b1; tick(); next = 1'b0; cyc = 1;
        while (!key_valid && cyc < 10) begin tick(); cyc++; end
        n_cmp++; if ({cyc, round, round_key, last} !== {32'd3, 4'(r), model_key(k, r), (r == 10)}) begin
          n_err++; $display("FAIL random_round: key=%h r=%0d got cyc=%0d round=%0d rk=%h last=%b want cyc=3 rk=%h", k, r, cyc, round, round_key, last, model_key(k, r));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; key_load = 1'b0; next = 1'b0; key = '0;
    build_sbox();
    @(negedge clk);
    test_reset();
    test_load();
    test_single_next();
    test_held_next();
    test_next_during_lookup();
    test_abort_load();
    test_reset_in_lookup();
    test_random_keys();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
